// File: rtl/drive_cmd_arbiter_if.sv
// Handshake bundle between command sources, the arbiter and the
// downstream transmitter.
// master: arbiter side (takes source strobes and cmd_ready, drives
//   cmd_out/cmd_src/cmd_valid/src_fresh).
// slave: environment side (sources and the downstream transmitter).
interface drive_cmd_arbiter_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned CMD_W   = 4
);
  localparam int unsigned SRC_W = $clog2(NUM_SRC + 1);

  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*CMD_W-1:0] src_cmd;
  logic [NUM_SRC-1:0]       src_en;
  logic [CMD_W-1:0]         cmd_out;
  logic [SRC_W-1:0]         cmd_src;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [NUM_SRC-1:0]       src_fresh;

  modport master (
    input  src_valid,
    input  src_cmd,
    input  src_en,
    input  cmd_ready,
    output cmd_out,
    output cmd_src,
    output cmd_valid,
    output src_fresh
  );

  modport slave (
    output src_valid,
    output src_cmd,
    output src_en,
    output cmd_ready,
    input  cmd_out,
    input  cmd_src,
    input  cmd_valid,
    input  src_fresh
  );
endinterface

// File: rtl/drive_cmd_arbiter.sv
// Merges drive commands from NUM_SRC sources into one downstream stream.
// Each source has a freshness timeout, a fixed priority (index 0 wins)
// and an enable mask. A command is offered only when the winning
// (cmd, src) pair changes, then held for a minimum dwell after it is
// accepted. With no fresh source the block falls back to STOP_CMD.
// Ports: clk_50, reset (sync, active high), bus (master modport):
//   src_valid/src_cmd/src_en in, cmd_out/cmd_src/cmd_valid out,
//   cmd_ready in, src_fresh out.
module drive_cmd_arbiter #(
  parameter int unsigned     NUM_SRC     = 3,
  parameter int unsigned     CMD_W       = 4,
  parameter int unsigned     TIMEOUT_CYC = 5_000_000,
  parameter int unsigned     HOLD_CYC    = 2_500_000,
  parameter logic [CMD_W-1:0] STOP_CMD   = '0
) (
  input logic clk_50,
  input logic reset,
  drive_cmd_arbiter_if.master bus
);

  localparam int unsigned SW = $clog2(NUM_SRC + 1);
  localparam int unsigned AW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DW =
    (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [AW-1:0] AGE_MAX  = AW'(TIMEOUT_CYC);
  localparam logic [SW-1:0] SRC_NONE = SW'(NUM_SRC);
  localparam logic [DW-1:0] DWELL_LD = DW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DWELL
  } state_e;

  logic [NUM_SRC*CMD_W-1:0] last_flat;
  logic [NUM_SRC-1:0]       fresh;

  // Per-source age counter and latched command.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [AW-1:0]    age_q, age_d;
    logic [CMD_W-1:0] last_q, last_d;

    always_comb begin
      age_d  = age_q;
      last_d = last_q;
      // A strobe beats saturation on the same edge.
      if (bus.src_valid[gi]) begin
        age_d  = '0;
        last_d = bus.src_cmd[gi*CMD_W +: CMD_W];
      end else if (age_q != AGE_MAX) begin
        age_d = age_q + 1'b1;
      end
    end

    always_ff @(posedge clk_50) begin
      if (reset) begin
        age_q  <= AGE_MAX;
        last_q <= STOP_CMD;
      end else begin
        age_q  <= age_d;
        last_q <= last_d;
      end
    end

    assign fresh[gi] = bus.src_en[gi] && (age_q < AGE_MAX);
    assign last_flat[gi*CMD_W +: CMD_W] = last_q;
  end

  assign bus.src_fresh = fresh;

  // Fixed priority: scan high to low so the lowest fresh index wins.
  logic [CMD_W-1:0] sel_cmd;
  logic [SW-1:0]    sel_src;

  always_comb begin
    sel_cmd = STOP_CMD;
    sel_src = SRC_NONE;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (fresh[i]) begin
        sel_cmd = last_flat[i*CMD_W +: CMD_W];
        sel_src = SW'(i);
      end
    end
  end

  state_e           state_q, state_d;
  logic [CMD_W-1:0] out_q, out_d;
  logic [SW-1:0]    src_q, src_d;
  logic             valid_q, valid_d;
  logic             force_q, force_d;
  logic [DW-1:0]    dwell_q, dwell_d;

  logic sel_diff;
  assign sel_diff = (sel_cmd != out_q) || (sel_src != src_q);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    src_d   = src_q;
    valid_d = valid_q;
    force_d = force_q;
    dwell_d = dwell_q;
    unique case (state_q)
      S_IDLE: begin
        // force_q makes the post-reset STOP announce unconditional.
        if (force_q || sel_diff) begin
          out_d   = sel_cmd;
          src_d   = sel_src;
          valid_d = 1'b1;
          force_d = 1'b0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (valid_q && bus.cmd_ready) begin
          valid_d = 1'b0;
          dwell_d = DWELL_LD;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (dwell_q == '0) begin
          state_d = S_IDLE;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= STOP_CMD;
      src_q   <= SRC_NONE;
      valid_q <= 1'b0;
      force_q <= 1'b1;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      force_q <= force_d;
      dwell_q <= dwell_d;
    end
  end

  assign bus.cmd_out   = out_q;
  assign bus.cmd_src   = src_q;
  assign bus.cmd_valid = valid_q;

  // An offer under backpressure must stay put.
  a_hold_stable: assert property (
    @(posedge clk_50) disable iff (reset)
    (valid_q && !bus.cmd_ready) |=>
      (valid_q && $stable(out_q) && $stable(src_q))
  );

endmodule
